// File: rtl/reg_file_sb.sv
// reg_file_sb: general-purpose register file with a pending-write scoreboard
// and a bulk-clear engine. Register 0 is hardwired to zero. Sub-word writes are
// sign- or zero-extended. Reads are either combinational with write-first bypass
// or registered with one cycle of latency. While a bulk clear runs, no new writes,
// issues or clear requests are accepted.
//
// Handshake note: this block has no valid/ready channels. Each request (we,
// issue_valid, clr_req) is a single-cycle strobe. It is sampled on the rising
// edge and takes effect only while the FSM is in IDLE. Nothing back-pressures the
// requester, so a strobe raised during CLEAR is dropped. The requester can watch
// clr_busy to know when that will happen.
module reg_file_sb #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int READ_REG = 0,
  localparam int AW      = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   Rs1,
  input  logic [AW-1:0]   Rs2,
  input  logic [AW-1:0]   Rd,
  input  logic [XLEN-1:0] data_in,
  input  logic            we,
  input  logic [1:0]      wr_size,
  input  logic            wr_unsigned,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  input  logic            clr_req,
  output logic [XLEN-1:0] read_data1,
  output logic [XLEN-1:0] read_data2,
  output logic            rs1_pending,
  output logic            rs2_pending,
  output logic            clr_busy,
  output logic            clr_done,
  output logic            fsm_state
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic            clr_done_q, clr_done_d;
  logic [XLEN-1:0] regs_q [NREG];
  logic [NREG-1:0] pending_q, pending_d;

  logic [XLEN-1:0] wv;
  logic            idle;
  logic            wr_acc;
  logic            iss_acc;
  logic [XLEN-1:0] rd1_c, rd2_c;

  assign idle    = (state_q == ST_IDLE);
  assign wr_acc  = we && (Rd != '0) && idle;
  assign iss_acc = issue_valid && (issue_rd != '0) && idle;

  // Write value: extend the low byte/half for sub-word sizes, full word otherwise.
  always_comb begin
    wv = data_in;
    case (wr_size)
      2'b00:   wv = wr_unsigned ? {{(XLEN-8){1'b0}}, data_in[7:0]}
                                : {{(XLEN-8){data_in[7]}}, data_in[7:0]};
      2'b01:   wv = wr_unsigned ? {{(XLEN-16){1'b0}}, data_in[15:0]}
                                : {{(XLEN-16){data_in[15]}}, data_in[15:0]};
      default: wv = data_in;
    endcase
  end

  // Clear FSM next state: IDLE -> CLEAR on request; walk the index from 1 to NREG-1.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    clr_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clr_req) begin
          state_d = ST_CLEAR;
          idx_d   = AW'(1);
        end
      end
      ST_CLEAR: begin
        idx_d = idx_q + AW'(1);
        if (idx_q == AW'(NREG - 1)) begin
          state_d    = ST_IDLE;
          idx_d      = '0;
          clr_done_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state, clear index and the done pulse (held for the first IDLE cycle).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      clr_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      clr_done_q <= clr_done_d;
    end
  end

  // Scoreboard next state: a clear wins in CLEAR; in IDLE an issue set beats a
  // same-edge write clear, because the issued instruction is the newer producer.
  always_comb begin
    pending_d = pending_q;
    if (state_q == ST_CLEAR) begin
      pending_d[idx_q] = 1'b0;
    end else begin
      if (wr_acc)  pending_d[Rd]       = 1'b0;
      if (iss_acc) pending_d[issue_rd] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pending_q <= '0;
    else      pending_q <= pending_d;
  end

  // Register array: bulk clear walks one entry per cycle; otherwise accepted writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (state_q == ST_CLEAR) begin
      regs_q[idx_q] <= '0;
    end else if (wr_acc) begin
      regs_q[Rd] <= wv;
    end
  end

  // Combinational read with write-first bypass; address 0 always reads zero.
  always_comb begin
    rd1_c = '0;
    rd2_c = '0;
    if (Rs1 != '0) rd1_c = (wr_acc && (Rd == Rs1)) ? wv : regs_q[Rs1];
    if (Rs2 != '0) rd2_c = (wr_acc && (Rd == Rs2)) ? wv : regs_q[Rs2];
  end

  generate
    if (READ_REG != 0) begin : g_read_reg
      logic [XLEN-1:0] rd1_q, rd2_q;
      // Registered read: capture the bypassed combinational value each edge.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          rd1_q <= '0;
          rd2_q <= '0;
        end else begin
          rd1_q <= rd1_c;
          rd2_q <= rd2_c;
        end
      end
      assign read_data1 = rd1_q;
      assign read_data2 = rd2_q;
    end else begin : g_read_comb
      assign read_data1 = rd1_c;
      assign read_data2 = rd2_c;
    end
  endgenerate

  // A write landing this cycle already satisfies the outstanding producer.
  assign rs1_pending = (Rs1 != '0) && pending_q[Rs1] && !(wr_acc && (Rd == Rs1));
  assign rs2_pending = (Rs2 != '0) && pending_q[Rs2] && !(wr_acc && (Rd == Rs2));

  assign clr_busy  = (state_q == ST_CLEAR);
  assign clr_done  = clr_done_q;
  assign fsm_state = state_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed bench for reg_file_sb. Instance a uses the default
// parameters (combinational read). Instance b uses NREG=8, XLEN=16 and a
// registered read.
module tb_reg_file_sb;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // instance a signals
  logic [4:0]  a_rs1 = '0, a_rs2 = '0, a_rd = '0, a_ird = '0;
  logic [31:0] a_din = '0;
  logic        a_we = 1'b0, a_wun = 1'b0, a_iv = 1'b0, a_clr = 1'b0;
  logic [1:0]  a_wsz = 2'b10;
  logic [31:0] a_rd1, a_rd2;
  logic        a_p1, a_p2, a_busy, a_done, a_st;

  // instance b signals
  logic [2:0]  b_rs1 = '0, b_rs2 = '0, b_rd = '0, b_ird = '0;
  logic [15:0] b_din = '0;
  logic        b_we = 1'b0, b_wun = 1'b0, b_iv = 1'b0, b_clr = 1'b0;
  logic [1:0]  b_wsz = 2'b10;
  logic [15:0] b_rd1, b_rd2;
  logic        b_p1, b_p2, b_busy, b_done, b_st;

  reg_file_sb #(.XLEN(32), .NREG(32), .READ_REG(0)) dut_a (
    .clk(clk), .rst(rst), .Rs1(a_rs1), .Rs2(a_rs2), .Rd(a_rd), .data_in(a_din),
    .we(a_we), .wr_size(a_wsz), .wr_unsigned(a_wun), .issue_valid(a_iv),
    .issue_rd(a_ird), .clr_req(a_clr), .read_data1(a_rd1), .read_data2(a_rd2),
    .rs1_pending(a_p1), .rs2_pending(a_p2), .clr_busy(a_busy), .clr_done(a_done),
    .fsm_state(a_st)
  );

  reg_file_sb #(.XLEN(16), .NREG(8), .READ_REG(1)) dut_b (
    .clk(clk), .rst(rst), .Rs1(b_rs1), .Rs2(b_rs2), .Rd(b_rd), .data_in(b_din),
    .we(b_we), .wr_size(b_wsz), .wr_unsigned(b_wun), .issue_valid(b_iv),
    .issue_rd(b_ird), .clr_req(b_clr), .read_data1(b_rd1), .read_data2(b_rd2),
    .rs1_pending(b_p1), .rs2_pending(b_p2), .clr_busy(b_busy), .clr_done(b_done),
    .fsm_state(b_st)
  );

  // ---------------- driver tasks ----------------
  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One-cycle write on instance a; the write lands at the next edge.
  task automatic a_write(input logic [4:0] rd, input logic [31:0] d,
                         input logic [1:0] sz, input logic uns);
    a_we = 1'b1; a_rd = rd; a_din = d; a_wsz = sz; a_wun = uns;
    step();
    a_we = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int cnt;
    int dcnt;

    // reset state
    #2;
    chk("rst_rd1", a_rd1, 32'h0);
    chk("rst_busy", {31'b0, a_busy}, 32'h0);
    chk("rst_done", {31'b0, a_done}, 32'h0);
    chk("rst_b_rd1", {16'h0, b_rd1}, 32'h0);
    #10 rst = 1'b1;
    step();
    a_rs1 = 5'd5;
    #1 chk("empty_x5", a_rd1, 32'h0);

    // word write with same-cycle bypass, then read back from storage
    a_we = 1'b1; a_rd = 5'd5; a_din = 32'hDEADBEEF; a_wsz = 2'b10;
    #1 chk("bypass_x5", a_rd1, 32'hDEADBEEF);
    step();
    a_we = 1'b0;
    #1 chk("stored_x5", a_rd1, 32'hDEADBEEF);

    // sub-word extension
    a_rs2 = 5'd3;
    a_write(5'd3, 32'h000000F0, 2'b00, 1'b0);
    #1 chk("byte_signed", a_rd2, 32'hFFFFFFF0);
    a_write(5'd3, 32'h000000F0, 2'b00, 1'b1);
    #1 chk("byte_unsigned", a_rd2, 32'h000000F0);
    a_write(5'd3, 32'h00008001, 2'b01, 1'b0);
    #1 chk("half_signed", a_rd2, 32'hFFFF8001);
    a_write(5'd3, 32'h12348001, 2'b01, 1'b1);
    #1 chk("half_unsigned", a_rd2, 32'h00008001);
    a_write(5'd3, 32'hCAFEF00D, 2'b11, 1'b0);
    #1 chk("word_sz11", a_rd2, 32'hCAFEF00D);

    // register zero
    a_rs1 = 5'd0; a_rs2 = 5'd0;
    a_we = 1'b1; a_rd = 5'd0; a_din = 32'h1234; a_wsz = 2'b10;
    #1 chk("x0_bypass1", a_rd1, 32'h0);
    chk("x0_bypass2", a_rd2, 32'h0);
    step();
    a_we = 1'b0; a_iv = 1'b1; a_ird = 5'd0;
    #1 chk("x0_read1", a_rd1, 32'h0);
    chk("x0_read2", a_rd2, 32'h0);
    step();
    a_iv = 1'b0;
    #1 chk("x0_pending", {31'b0, a_p1}, 32'h0);

    // scoreboard
    a_iv = 1'b1; a_ird = 5'd7;
    step();
    a_iv = 1'b0; a_rs2 = 5'd7; a_rs1 = 5'd7;
    #1 chk("pend_set", {31'b0, a_p2}, 32'h1);
    a_we = 1'b1; a_rd = 5'd7; a_din = 32'h77; a_wsz = 2'b10;
    #1 chk("pend_mask_wr", {31'b0, a_p2}, 32'h0);
    step();
    a_we = 1'b0;
    #1 chk("pend_cleared", {31'b0, a_p2}, 32'h0);
    chk("x7_value", a_rd1, 32'h77);
    a_iv = 1'b1; a_ird = 5'd7; a_we = 1'b1; a_rd = 5'd7; a_din = 32'h88;
    step();
    a_iv = 1'b0; a_we = 1'b0;
    #1 chk("pend_set_wins", {31'b0, a_p2}, 32'h1);
    chk("pend_set_wins_p1", {31'b0, a_p1}, 32'h1);

    // fill, then bulk clear with ignored traffic
    for (int i = 1; i < 32; i++) a_write(5'(i), {4{8'(i)}}, 2'b10, 1'b0);
    a_iv = 1'b1; a_ird = 5'd6;
    step();
    a_iv = 1'b0; a_rs1 = 5'd6;
    #1 chk("fill_x6_pend", {31'b0, a_p1}, 32'h1);
    chk("fill_x6", a_rd1, 32'h06060606);
    a_clr = 1'b1;
    step();
    a_clr = 1'b0;
    a_we = 1'b1; a_rd = 5'd31; a_din = 32'hFFFF_FFFF; a_wsz = 2'b10;
    a_iv = 1'b1; a_ird = 5'd4; a_rs1 = 5'd31; a_rs2 = 5'd4;
    #1 chk("clr_busy_first", {31'b0, a_busy}, 32'h1);
    chk("clr_no_bypass", a_rd1, 32'h1F1F1F1F);
    cnt = 0; dcnt = 0;
    for (int k = 0; k < 100; k++) begin
      if (!a_busy) break;
      cnt++;
      if (a_done) dcnt++;
      if (cnt == 20) begin
        chk("clr_wr_ignored", a_rd1, 32'h1F1F1F1F);
        chk("clr_iss_ignored", {31'b0, a_p2}, 32'h0);
        a_we = 1'b0; a_iv = 1'b0;
      end
      step();
      #1;
    end
    chk("clr_cycles", cnt, 32'd31);
    chk("clr_done_during", dcnt, 32'd0);
    chk("clr_done_pulse", {31'b0, a_done}, 32'h1);
    step();
    #1 chk("clr_done_low", {31'b0, a_done}, 32'h0);
    for (int i = 1; i < 32; i++) begin
      a_rs1 = 5'(i); a_rs2 = 5'(i);
      #1;
      if (a_rd1 !== 32'h0 || a_rd2 !== 32'h0 || a_p1 !== 1'b0) begin
        chk($sformatf("clr_zero_x%0d", i), {a_rd1 | a_rd2} | {31'b0, a_p1}, 32'h0);
      end else begin
        chk($sformatf("clr_zero_x%0d", i), a_rd1 | a_rd2, 32'h0);
      end
    end

    // reset in the middle of a clear
    step();
    a_write(5'd2, 32'h22222222, 2'b10, 1'b0);
    a_write(5'd20, 32'h14141414, 2'b10, 1'b0);
    a_clr = 1'b1;
    step();
    a_clr = 1'b0;
    repeat (9) step();
    a_rs1 = 5'd20; a_rs2 = 5'd2;
    #1 chk("mid_clr_busy", {31'b0, a_busy}, 32'h1);
    chk("mid_clr_x20", a_rd1, 32'h14141414);
    rst = 1'b0;
    #1 chk("rst_mid_busy", {31'b0, a_busy}, 32'h0);
    chk("rst_mid_done", {31'b0, a_done}, 32'h0);
    chk("rst_mid_x20", a_rd1, 32'h0);
    #2 rst = 1'b1;
    step();
    a_rs2 = 5'd9;
    a_write(5'd9, 32'h0000_0099, 2'b10, 1'b0);
    #1 chk("post_rst_write", a_rd2, 32'h99);
    chk("post_rst_x20", a_rd1, 32'h0);

    // registered-read instance: one cycle of latency
    b_we = 1'b1; b_rd = 3'd2; b_din = 16'hABCD; b_wsz = 2'b10;
    step();
    b_we = 1'b0; b_rs1 = 3'd2;
    #1 chk("b_lat0", {16'h0, b_rd1}, 32'h0);
    step();
    chk("b_lat1", {16'h0, b_rd1}, 32'h0000ABCD);
    b_we = 1'b1; b_rd = 3'd3; b_din = 16'h0080; b_wsz = 2'b00; b_wun = 1'b0; b_rs2 = 3'd3;
    #1 chk("b_bypass_before", {16'h0, b_rd2}, 32'h0);
    step();
    b_we = 1'b0;
    #1 chk("b_bypass_after", {16'h0, b_rd2}, 32'h0000FF80);
    b_rs1 = 3'd0;
    step();
    chk("b_x0", {16'h0, b_rd1}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard time limit so the bench always ends.
  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32, register data width.
REQ-002 SHALL have parameter NREG, default 32, register count (power of 2, >=4); AW = log2(NREG).
REQ-003 SHALL have parameter READ_REG, default 0; 0 = combinational read, 1 = registered read.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low (asserted when 0).
REQ-006 Rs1  input  AW  read port 1 address.
REQ-007 Rs2  input  AW  read port 2 address.
REQ-008 Rd  input  AW  write address.
REQ-009 data_in  input  XLEN  write data; low bits used for sub-word sizes.
REQ-010 we  input  1  write enable.
REQ-011 wr_size  input  2  00 byte, 01 half, 10/11 full word.
REQ-012 wr_unsigned  input  1  1 = zero-extend sub-word writes, 0 = sign-extend.
REQ-013 issue_valid  input  1  marks issue_rd as having a pending write.
REQ-014 issue_rd  input  AW  destination being issued.
REQ-015 clr_req  input  1  start bulk clear.
REQ-016 read_data1  output  XLEN  port 1 data.
REQ-017 read_data2  output  XLEN  port 2 data.
REQ-018 rs1_pending  output  1  Rs1 has an outstanding write.
REQ-019 rs2_pending  output  1  Rs2 has an outstanding write.
REQ-020 clr_busy  output  1  bulk clear in progress.
REQ-021 clr_done  output  1  one-cycle pulse when clear completes.

Function
REQ-022 Write value (wv) SHALL be data_in[7:0] or data_in[15:0] extended per wr_unsigned for byte/half, data_in unchanged for word.
REQ-023 When we=1, Rd!=0 and FSM in IDLE, reg[Rd] SHALL take wv at the clock edge; writes to Rd=0 SHALL be discarded.
REQ-024 Reads of address 0 SHALL return 0 on both ports in all modes.
REQ-025 READ_REG=0: read_dataN SHALL be combinational; if we=1, Rd==RsN, RsN!=0, IDLE, it SHALL return wv (write-first bypass), else reg[RsN].
REQ-026 READ_REG=1: read_dataN SHALL present, one cycle after the edge, the value REQ-025 gives at that edge (latency 1).
REQ-027 Scoreboard: pending[i] SHALL set on the edge where issue_valid=1, issue_rd=i, i!=0, IDLE.
REQ-028 pending[Rd] SHALL clear on an accepted write (REQ-023).
REQ-029 Same-edge issue and write to one register: set SHALL win (new producer outstanding).
REQ-030 rsN_pending SHALL be pending[RsN] & ~(accepted write to RsN this cycle), forced 0 for RsN=0; combinational in both READ_REG modes.
REQ-031 FSM states IDLE, CLEAR; IDLE->CLEAR on clr_req=1, index loaded with 1.
REQ-032 In CLEAR each cycle: reg[index]<=0, pending[index]<=0, index increments; at index=NREG-1 SHALL return to IDLE and pulse clr_done for exactly that transition cycle+1 (one cycle, after last clear).
REQ-033 Clear SHALL take exactly NREG-1 cycles; clr_busy=1 for all CLEAR cycles only.
REQ-034 During CLEAR, we, issue_valid and clr_req SHALL be ignored; reads return stored contents, no bypass.

Reset
REQ-035 rst=0 SHALL immediately zero all registers, pending bits, index, read_data1/2 (READ_REG=1 pipeline), clr_busy, clr_done, and force IDLE, including mid-clear.
REQ-036 First operation after rst release SHALL behave as from IDLE with empty file.

Verification
REQ-037 Write x5=0xDEADBEEF word, then Rs1=5 -> read_data1=0xDEADBEEF; same-cycle bypass returns it in READ_REG=0.
REQ-038 Byte write 0x000000F0 to x3, wr_unsigned=0 -> 0xFFFFFFF0; wr_unsigned=1 -> 0x000000F0; half 0x8001 signed -> 0xFFFF8001.
REQ-039 Write 0x1234 to x0, read Rs1=Rs2=0 -> both 0; issue_rd=0 -> rs1_pending stays 0.
REQ-040 Issue x7, Rs2=7 -> rs2_pending=1; write x7 next cycle -> rs2_pending=0 that cycle; same-edge issue+write x7 -> pending remains 1.
REQ-041 Fill regs, clr_req -> clr_busy high 31 cycles (NREG=32), writes ignored, clr_done one pulse, all reads 0; assert rst at cycle 10 -> clr_busy=0 immediately, all zero.
REQ-042 READ_REG=1, NREG=8, XLEN=16: write x2=0xABCD then read -> value appears one cycle after address.
